pc_fetch_unit: RTL

Parametrised program-counter and fetch-steering unit for the RISC-V core front end, a successor to the fixed 32-bit branch/increment program counter. Generates the fetch address each cycle and arbitrates between the sequential, branch, trap, halt/stall and return-prediction sources. An optional return-address stack (RAS) predicts function returns. Sits between the decode/execute redirect logic and instruction memory.

---
 rtl/pc_pkg.sv | 5 +
 rtl/pc_ras.sv | 53 +++++
 rtl/pc_fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared state and next-PC source encodings for the fetch unit
package pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALTED} pc_state_t;
    typedef enum logic [2:0] {SEQ, BRANCH, TRAP, RAS, HOLD} pc_src_t;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; push+pop together replaces the top, a push when full drops the oldest
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   wp_q, wp_d, top_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    assign top_idx = wp_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(RAS_DEPTH);
    // next stack contents, write pointer and occupancy
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (push && pop) begin
            mem_d[top_idx] = wdata;
        end else if (push) begin
            mem_d[wp_q] = wdata;
            wp_d        = wp_q + PW'(1);
            cnt_d       = full ? cnt_q : cnt_q + CW'(1);
        end else if (pop) begin
            wp_d  = top_idx;
            cnt_d = cnt_q - CW'(1);
        end
    end
    // stack registers, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch steering; return-address stack enabled by PC_RAS_EN
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] INC          = XLEN'(4),
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            takeBranch,
    input  logic [XLEN-1:0] branchAddress,
    input  logic            trapTaken,
    input  logic [XLEN-1:0] trapVector,
    input  logic            haltReq,
    input  logic            resume,
    input  logic            callPush,
    input  logic            retPredict,
    output logic [XLEN-1:0] pcAddress,
    output logic            pcValid,
    output logic            redirect,
    output logic            rasEmpty,
    output logic            rasFull
);
    pc_state_t       state_q, state_d;
    pc_src_t         src;
    logic [XLEN-1:0] pc_q, pc_d, seq_pc, ras_top;
    logic            valid_q, valid_d, redirect_q, redirect_d, boot_q, boot_d;
    logic            live, call_i, ret_i, ras_push, ras_pop, ras_empty, ras_full;
    assign seq_pc = pc_q + INC;
`ifdef PC_RAS_EN
    assign call_i = callPush;
    assign ret_i  = retPredict;
    pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .wdata (seq_pc),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );
`else
    logic unused_ras;
    assign call_i     = 1'b0;
    assign ret_i      = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign unused_ras = ^{callPush, retPredict, ras_push, ras_pop};
`endif
    // next-PC source select, state transition and registered output values
    always_comb begin
        live       = state_q == RUN && !trapTaken && !takeBranch && !stall && !haltReq;
        ras_pop    = live && ret_i && !ras_empty;
        ras_push   = live && call_i;
        src        = state_q == BOOT ? HOLD : trapTaken ? TRAP : state_q == HALTED ? HOLD :
                     takeBranch ? BRANCH : (stall || haltReq) ? HOLD : ras_pop ? RAS : SEQ;
        state_d    = state_q == BOOT ? (boot_q ? BOOT : RUN) :
                     state_q == HALTED ? ((trapTaken || resume) ? RUN : HALTED) :
                     (haltReq && !trapTaken && !takeBranch) ? HALTED : RUN;
        pc_d       = src == TRAP ? trapVector : src == BRANCH ? branchAddress :
                     src == RAS ? ras_top : src == SEQ ? seq_pc : pc_q;
        redirect_d = src inside {TRAP, BRANCH, RAS};
        valid_d    = state_d == RUN;
        boot_d     = 1'b0;
    end
    // state and output registers; boot_q keeps BOOT for one cycle after reset releases
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            boot_q     <= 1'b1;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_q     <= boot_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
        end
    end
    assign pcAddress = pc_q;
    assign pcValid   = valid_q;
    assign redirect  = redirect_q;
    assign rasEmpty  = ras_empty;
    assign rasFull   = ras_full;
endmodule
